// File: rtl/axis_s2mm_arbiter.sv
// Packet round-robin merge of four weighted-channel AXI-Stream inputs onto one S2MM stream.
// Ports: clock/reset, enable, s00/s01/s20/s21 AXIS slaves, m_axis_s2mm master (+tdest), busy, len_err.
module axis_s2mm_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int MAX_BEATS  = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s00_axis_tkeep,
  input  logic                  s00_axis_tvalid,
  input  logic                  s00_axis_tlast,
  output logic                  s00_axis_tready,
  input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s01_axis_tkeep,
  input  logic                  s01_axis_tvalid,
  input  logic                  s01_axis_tlast,
  output logic                  s01_axis_tready,
  input  logic [DATA_WIDTH-1:0] s20_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s20_axis_tkeep,
  input  logic                  s20_axis_tvalid,
  input  logic                  s20_axis_tlast,
  output logic                  s20_axis_tready,
  input  logic [DATA_WIDTH-1:0] s21_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s21_axis_tkeep,
  input  logic                  s21_axis_tvalid,
  input  logic                  s21_axis_tlast,
  output logic                  s21_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_s2mm_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_s2mm_tkeep,
  output logic                  m_axis_s2mm_tvalid,
  output logic                  m_axis_s2mm_tlast,
  output logic [1:0]            m_axis_s2mm_tdest,
  input  logic                  m_axis_s2mm_tready,
  output logic                  busy,
  output logic [3:0]            len_err
);

  localparam logic [0:0]  IDLE     = 1'b0;
  localparam logic [0:0]  PASS     = 1'b1;
  localparam logic [15:0] CNT_LAST = 16'(MAX_BEATS - 1);

  logic [0:0]            state;
  logic [1:0]            ptr;
  logic [1:0]            grant;
  logic [15:0]           cnt;

  logic [DATA_WIDTH-1:0] in_data [4];
  logic [KEEP_WIDTH-1:0] in_keep [4];
  logic [3:0]            in_valid;
  logic [3:0]            in_last;
  logic [3:0]            in_ready;

  logic [1:0]            nxt_grant;
  logic [1:0]            idx;
  logic                  found;
  logic                  out_free;
  logic                  pass_rdy;
  logic                  accept;
  logic                  cnt_hit;
  logic                  sel_last;
  logic                  end_beat;

  assign in_data[0] = s00_axis_tdata;
  assign in_data[1] = s01_axis_tdata;
  assign in_data[2] = s20_axis_tdata;
  assign in_data[3] = s21_axis_tdata;
  assign in_keep[0] = s00_axis_tkeep;
  assign in_keep[1] = s01_axis_tkeep;
  assign in_keep[2] = s20_axis_tkeep;
  assign in_keep[3] = s21_axis_tkeep;

  assign in_valid = {s21_axis_tvalid, s20_axis_tvalid,
                     s01_axis_tvalid, s00_axis_tvalid};
  assign in_last  = {s21_axis_tlast, s20_axis_tlast,
                     s01_axis_tlast, s00_axis_tlast};

  // First requester at or after ptr, wrapping 3 -> 0.
  always_comb begin
    nxt_grant = ptr;
    found     = 1'b0;
    idx       = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        nxt_grant = idx;
        found     = 1'b1;
      end
    end
  end

  // The output register can take a beat if empty or draining this cycle.
  assign out_free = ~m_axis_s2mm_tvalid | m_axis_s2mm_tready;
  assign pass_rdy = (state == PASS) & out_free;
  assign in_ready = pass_rdy ? (4'b0001 << grant) : 4'b0000;
  assign accept   = pass_rdy & in_valid[grant];
  assign sel_last = in_last[grant];
  assign cnt_hit  = (cnt == CNT_LAST);
  assign end_beat = accept & (sel_last | cnt_hit);

  assign s00_axis_tready = in_ready[0];
  assign s01_axis_tready = in_ready[1];
  assign s20_axis_tready = in_ready[2];
  assign s21_axis_tready = in_ready[3];

  assign busy = (state == PASS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      grant   <= 2'd0;
      cnt     <= 16'd0;
      len_err <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && found) begin
            grant <= nxt_grant;
            cnt   <= 16'd0;
            state <= PASS;
          end
        end
        PASS: begin
          if (accept)
            cnt <= cnt + 16'd1;
          if (end_beat) begin
            ptr   <= grant + 2'd1;
            state <= IDLE;
            // Truncated packet: rest of it gets arbitrated afresh.
            if (!sel_last)
              len_err[grant] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_axis_s2mm_tvalid <= 1'b0;
      m_axis_s2mm_tlast  <= 1'b0;
      m_axis_s2mm_tdata  <= '0;
      m_axis_s2mm_tkeep  <= '0;
      m_axis_s2mm_tdest  <= 2'd0;
    end else if (accept) begin
      m_axis_s2mm_tvalid <= 1'b1;
      m_axis_s2mm_tlast  <= sel_last | cnt_hit;
      m_axis_s2mm_tdata  <= in_data[grant];
      m_axis_s2mm_tkeep  <= in_keep[grant];
      m_axis_s2mm_tdest  <= grant;
    end else if (m_axis_s2mm_tready) begin
      m_axis_s2mm_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_s2mm_arbiter.sv
// Randomized bench for axis_s2mm_arbiter with a queue-based reference model.
// Ports: drives all four AXIS slaves, DMA ready, enable and reset.
module tb_axis_s2mm_arbiter;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int MB = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] s_data [4];
  logic [KW-1:0] s_keep [4];
  logic [3:0]    s_vld = 4'd0;
  logic [3:0]    s_lst = 4'd0;
  logic [3:0]    s_rdy;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_vld;
  logic          m_last;
  logic [1:0]    m_dest;
  logic          m_rdy = 1'b0;
  logic          busy;
  logic [3:0]    len_err;

  always #5 clock = ~clock;

  axis_s2mm_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(MB)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .s00_axis_tdata(s_data[0]), .s00_axis_tkeep(s_keep[0]),
    .s00_axis_tvalid(s_vld[0]), .s00_axis_tlast(s_lst[0]),
    .s00_axis_tready(s_rdy[0]),
    .s01_axis_tdata(s_data[1]), .s01_axis_tkeep(s_keep[1]),
    .s01_axis_tvalid(s_vld[1]), .s01_axis_tlast(s_lst[1]),
    .s01_axis_tready(s_rdy[1]),
    .s20_axis_tdata(s_data[2]), .s20_axis_tkeep(s_keep[2]),
    .s20_axis_tvalid(s_vld[2]), .s20_axis_tlast(s_lst[2]),
    .s20_axis_tready(s_rdy[2]),
    .s21_axis_tdata(s_data[3]), .s21_axis_tkeep(s_keep[3]),
    .s21_axis_tvalid(s_vld[3]), .s21_axis_tlast(s_lst[3]),
    .s21_axis_tready(s_rdy[3]),
    .m_axis_s2mm_tdata(m_data), .m_axis_s2mm_tkeep(m_keep),
    .m_axis_s2mm_tvalid(m_vld), .m_axis_s2mm_tlast(m_last),
    .m_axis_s2mm_tdest(m_dest), .m_axis_s2mm_tready(m_rdy),
    .busy(busy), .len_err(len_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  beat_t src_q [4][$];
  beat_t exp_q [4][$];
  int    exp_g_q [$];
  int    dest_log [$];
  int    start_cyc_q [$];
  int    out_cyc_q [$];
  logic  open_pkt [4];
  logic [3:0] hs = 4'd0;
  logic [3:0] m_len_err = 4'd0;
  int    mptr = 0;
  int    obeats = 0;
  logic [1:0] odest = 2'd0;
  int    cyc = 0;
  int    n_out = 0;
  int    vprob = 100;
  int    rmode = 0;
  logic  en_rand = 1'b0;
  logic [3:0] pat = 4'b1001;
  logic  p_busy = 1'b0;
  logic  p_en = 1'b0;
  logic [3:0] p_valid = 4'd0;
  logic  p_stall = 1'b0;
  logic [74:0] p_out = '0;
  int    t_req;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic gen_pkt(input int ch, input int len, input bit last,
                         input bit seq);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = seq ? DW'(i + 1) : {$urandom, $urandom};
      b.k = seq ? '1 : KW'($urandom);
      b.l = last && (i == len - 1);
      src_q[ch].push_back(b);
      exp_q[ch].push_back(b);
    end
    open_pkt[ch] = !last;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        void'(src_q[i].pop_front());
        s_vld[i] = 1'b0;
        hs[i]    = 1'b0;
      end
      if (!s_vld[i] && src_q[i].size() > 0 &&
          $urandom_range(0, 99) < vprob)
        s_vld[i] = 1'b1;
      if (s_vld[i]) begin
        s_data[i] = src_q[i][0].d;
        s_keep[i] = src_q[i][0].k;
        s_lst[i]  = src_q[i][0].l;
      end else begin
        s_data[i] = '0;
        s_keep[i] = '0;
        s_lst[i]  = 1'b0;
      end
    end
    case (rmode)
      0: m_rdy = 1'b1;
      1: m_rdy = ($urandom_range(0, 3) != 0);
      default: m_rdy = pat[cyc % 4];
    endcase
    enable = en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
  endtask

  task automatic monitor();
    logic [1:0]  g;
    logic        found;
    logic        el;
    beat_t       e;
    int          d;
    logic [74:0] cur;
    cyc++;
    hs = s_vld & s_rdy;
    chk("rdy_onehot", 128'($countones(s_rdy) <= 1), 1);
    chk("rdy_idle", (|s_rdy) & ~busy, 0);
    if (m_vld & ~m_rdy)
      chk("rdy_stall", s_rdy, 0);
    if (!p_busy) begin
      el = p_en & (|p_valid);
      chk("grant_start", busy, el);
      if (busy & el) begin
        g = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && p_valid[(mptr + k) % 4]) begin
            g = 2'((mptr + k) % 4);
            found = 1'b1;
          end
        end
        exp_g_q.push_back(int'(g));
        mptr = (int'(g) + 1) % 4;
      end
    end
    cur = {m_data, m_keep, m_last, m_dest};
    if (p_stall) begin
      chk("stall_vld", m_vld, 1);
      chk("stall_hold", cur, p_out);
    end
    if (m_vld & m_rdy) begin
      d = int'(m_dest);
      out_cyc_q.push_back(cyc);
      n_out++;
      if (obeats == 0) begin
        start_cyc_q.push_back(cyc);
        dest_log.push_back(d);
        if (exp_g_q.size() == 0)
          chk("grant_known", 0, 1);
        else
          chk("pkt_dest", m_dest, exp_g_q.pop_front());
      end else begin
        chk("pkt_contig", m_dest, odest);
      end
      if (exp_q[d].size() == 0) begin
        chk("beat_known", 0, 1);
      end else begin
        e = exp_q[d].pop_front();
        chk("tdata", m_data, e.d);
        chk("tkeep", m_keep, e.k);
        el = e.l | (obeats + 1 == MB);
        chk("tlast", m_last, el);
        if (el & ~e.l)
          m_len_err[d] = 1'b1;
        obeats = el ? 0 : obeats + 1;
      end
      odest = m_dest;
    end
    p_busy  = busy;
    p_en    = enable;
    p_valid = s_vld;
    p_stall = m_vld & ~m_rdy;
    p_out   = cur;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    drive();
    @(negedge clock);
    monitor();
  endtask

  task automatic rst_check();
    chk("rst_tready", s_rdy, 0);
    chk("rst_tvalid", m_vld, 0);
    chk("rst_tlast", m_last, 0);
    chk("rst_tdata", m_data, 0);
    chk("rst_tkeep", m_keep, 0);
    chk("rst_tdest", m_dest, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len_err", len_err, 0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    cyc++;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      open_pkt[i] = 1'b0;
    end
    exp_g_q.delete();
    s_vld = 4'd0;
    s_lst = 4'd0;
    hs = 4'd0;
    mptr = 0;
    obeats = 0;
    m_len_err = 4'd0;
    @(negedge clock);
    cyc++;
    rst_check();
    @(posedge clock);
    #1;
    reset   = 1'b0;
    p_busy  = 1'b0;
    p_en    = 1'b0;
    p_valid = 4'd0;
    p_stall = 1'b0;
    drive();
    @(negedge clock);
    monitor();
  endtask

  task automatic drain();
    int  n;
    logic done;
    for (int i = 0; i < 4; i++)
      if (open_pkt[i])
        gen_pkt(i, 1, 1'b1, 1'b0);
    n = 0;
    done = 1'b0;
    while (!done && n < 500) begin
      cycle();
      n++;
      done = !m_vld && !busy && (hs == 4'd0);
      for (int i = 0; i < 4; i++)
        if (src_q[i].size() != 0)
          done = 1'b0;
    end
    if (!done)
      chk("drain_timeout", 1, 0);
    for (int i = 0; i < 4; i++)
      chk("leftover", exp_q[i].size(), 0);
    chk("grants_left", exp_g_q.size(), 0);
    chk("len_err", len_err, m_len_err);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      s_data[i] = '0;
      s_keep[i] = '0;
      open_pkt[i] = 1'b0;
    end
    do_reset();

    // All four channels request together.
    for (int i = 0; i < 4; i++)
      gen_pkt(i, 2, 1'b1, 1'b0);
    gen_pkt(0, 2, 1'b1, 1'b0);
    dest_log.delete();
    start_cyc_q.delete();
    drain();
    chk("order_count", dest_log.size(), 5);
    if (dest_log.size() >= 5) begin
      chk("order0", dest_log[0], 0);
      chk("order1", dest_log[1], 1);
      chk("order2", dest_log[2], 2);
      chk("order3", dest_log[3], 3);
      chk("order4", dest_log[4], 0);
      for (int i = 1; i < 5; i++)
        chk("pkt_gap", start_cyc_q[i] - start_cyc_q[i-1], 3);
    end

    // Single channel 20, data 1..4, latency.
    gen_pkt(2, 4, 1'b1, 1'b1);
    out_cyc_q.delete();
    cycle();
    t_req = cyc;
    drain();
    chk("single_beats", out_cyc_q.size(), 4);
    if (out_cyc_q.size() >= 4)
      for (int j = 0; j < 4; j++)
        chk("single_lat", out_cyc_q[j] - t_req, 2 + j);
    chk("single_len_err", len_err, 0);

    // Length limit on channel 01.
    gen_pkt(1, 6, 1'b0, 1'b0);
    gen_pkt(1, 2, 1'b1, 1'b0);
    start_cyc_q.delete();
    drain();
    chk("trunc_len_err", len_err, 4'b0010);
    chk("trunc_pkts", start_cyc_q.size(), 2);

    // Backpressure 1,0,0,1 on an 8-beat packet.
    rmode = 2;
    n_out = 0;
    gen_pkt(3, 8, 1'b1, 1'b0);
    drain();
    chk("bp_beats", n_out, 8);
    rmode = 0;

    // Random traffic with random enable and DMA stalls.
    rmode = 1;
    en_rand = 1'b1;
    vprob = 60;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int ch;
        ch = $urandom_range(0, 3);
        if (src_q[ch].size() < 16)
          gen_pkt(ch, $urandom_range(1, 7),
                  $urandom_range(0, 4) != 0, 1'b0);
      end
      cycle();
    end
    en_rand = 1'b0;
    drain();
    rmode = 0;
    vprob = 100;

    // Reset in the middle of a packet.
    for (int i = 0; i < 4; i++)
      gen_pkt(i, 4, 1'b1, 1'b0);
    repeat (4) cycle();
    do_reset();
    gen_pkt(3, 1, 1'b1, 1'b0);
    gen_pkt(0, 1, 1'b1, 1'b0);
    dest_log.delete();
    drain();
    chk("post_rst_cnt", dest_log.size(), 2);
    if (dest_log.size() >= 1)
      chk("post_rst_first", dest_log[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
